i2c_slave_regs: RTL and testbench

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_bus_sync.sv | 35 +++
 rtl/i2c_slave_regs.sv | 188 ++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b1101001;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [1:0] are the synchronizer stages, [2] holds the previous synchronized value
  logic [2:0] scl_pipe;
  logic [2:0] sda_pipe;

  // Synchronizer and history flops, idle-high out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_pipe <= 3'b111;
      sda_pipe <= 3'b111;
    end else begin
      scl_pipe <= {scl_pipe[1:0], scl_in};
      sda_pipe <= {sda_pipe[1:0], sda_in};
    end
  end

  assign sda      = sda_pipe[1];
  assign scl_rise =  scl_pipe[1] & ~scl_pipe[2];
  assign scl_fall = ~scl_pipe[1] &  scl_pipe[2];
  assign start    =  sda_pipe[2] & ~sda_pipe[1] & scl_pipe[1] & scl_pipe[2];
  assign stop     = ~sda_pipe[2] &  sda_pipe[1] & scl_pipe[1] & scl_pipe[2];

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing REG_DEPTH 8-bit registers; pointer auto-increment
// after each data byte is enabled by defining I2C_SLAVE_AUTOINC_EN.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int         REG_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int PW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  logic          sda;
  logic          scl_rise;
  logic          scl_fall;
  logic          start;
  logic          stop;
  i2c_state_e    state;
  logic [3:0]    bit_cnt;
  logic [6:0]    shift;
  logic [1:0]    phase;
  logic          is_read;
  logic [PW-1:0] ptr;
  logic [7:0]    regs [REG_DEPTH];
  logic [7:0]    rx_byte;
  logic [2:0]    rd_idx;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign rx_byte = {shift, sda};
  assign rd_idx  = 3'd7 - bit_cnt[2:0];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
`ifdef I2C_SLAVE_AUTOINC_EN
    return p + PW'(1);
`else
    return p;
`endif
  endfunction

  // Protocol FSM, register file and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 7'd0;
      phase     <= 2'd0;
      is_read   <= 1'b0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 8'd0;
      busy      <= 1'b0;
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (start) begin
        state   <= ST_ADDR;
        bit_cnt <= 4'd0;
        phase   <= 2'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
          end
          ST_ADDR, ST_REG, ST_WDATA: begin
            if (scl_rise) begin
              shift   <= {shift[5:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                phase   <= 2'd0;
                case (state)
                  ST_ADDR: begin
                    if (rx_byte[7:1] == SLAVE_ADDR) begin
                      busy    <= 1'b1;
                      is_read <= rx_byte[0];
                      state   <= ST_ADDR_ACK;
                    end else begin
                      state <= ST_IDLE;
                    end
                  end
                  ST_REG: begin
                    if ({1'b0, rx_byte} < 9'(REG_DEPTH)) begin
                      ptr   <= rx_byte[PW-1:0];
                      state <= ST_REG_ACK;
                    end else begin
                      busy  <= 1'b0;
                      state <= ST_IDLE;
                    end
                  end
                  default: begin
                    regs[ptr] <= rx_byte;
                    wr_strobe <= 1'b1;
                    wr_addr   <= 8'(ptr);
                    wr_data   <= rx_byte;
                    ptr       <= next_ptr(ptr);
                    state     <= ST_WDATA_ACK;
                  end
                endcase
              end
            end
          end
          ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
            // phase 0: drive ACK on the fall, 1: wait for the 9th rise, 2: release on the fall
            case (phase)
              2'd0: if (scl_fall) begin sda_oe <= ~ACK; phase <= 2'd1; end
              2'd1: if (scl_rise) phase <= 2'd2;
              2'd2: begin
                if (scl_fall) begin
                  phase   <= 2'd0;
                  bit_cnt <= 4'd0;
                  sda_oe  <= 1'b0;
                  if (state == ST_ADDR_ACK && is_read) begin
                    sda_oe <= ~regs[ptr][7];
                    state  <= ST_RDATA;
                  end else if (state == ST_ADDR_ACK) begin
                    state <= ST_REG;
                  end else begin
                    state <= ST_WDATA;
                  end
                end
              end
              default: phase <= 2'd0;
            endcase
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                ptr    <= next_ptr(ptr);
                phase  <= 2'd0;
                state  <= ST_RDATA_ACK;
              end else begin
                sda_oe <= ~regs[ptr][rd_idx];
              end
            end
          end
          ST_RDATA_ACK: begin
            // phase 3 parks after a master NACK until START/STOP
            case (phase)
              2'd0: if (scl_rise) phase <= (sda == ACK) ? 2'd1 : 2'd3;
              2'd1: begin
                if (scl_fall) begin
                  bit_cnt <= 4'd0;
                  phase   <= 2'd0;
                  sda_oe  <= ~regs[ptr][7];
                  state   <= ST_RDATA;
                end
              end
              2'd3: phase <= 2'd3;
              default: phase <= 2'd0;
            endcase
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Randomized bench with a transaction-level register model and queue scoreboard.
module tb_i2c_slave_regs;

  localparam int Q = 8;
  localparam logic [6:0] MY_ADDR = 7'h69;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_wr[$];
  logic [8:0]  exp_bus[$];
  logic [8:0]  act_bus[$];

  logic [7:0] mregs[16];
  int         mptr = 0;

  assign sda_line = m_sda & ~sda_oe;

  i2c_slave_regs #(.SLAVE_ADDR(MY_ADDR), .REG_DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_adv();
`ifdef I2C_SLAVE_AUTOINC_EN
    mptr = (mptr + 1) % 16;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;
  endfunction

  task automatic bus_bit(input logic b, output logic s);
    m_sda = b; hold(Q);
    scl = 1'b1; hold(Q);
    s = sda_line; hold(Q);
    scl = 1'b0; hold(Q);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; hold(Q);
    scl = 1'b1; hold(Q);
    m_sda = 1'b0; hold(Q);
    scl = 1'b0; hold(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; hold(Q);
    scl = 1'b1; hold(Q);
    m_sda = 1'b1; hold(Q);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    act_bus.push_back({1'b0, 7'd0, s});
  endtask

  task automatic recv_byte(input logic mack);
    logic [7:0] v;
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      v[i] = s;
    end
    bus_bit(mack, s);
    act_bus.push_back({1'b1, v});
  endtask

  // Address (+W), register index, n data bytes; open=1 means bus left claimed for a repeated START
  task automatic write_txn(input logic [6:0] a, input int r, input int n,
                           input logic [23:0] data, input bit do_stop, output bit open);
    logic [7:0] d;
    open = 1'b0;
    bus_start();
    exp_bus.push_back({1'b0, 7'd0, (a == MY_ADDR) ? 1'b0 : 1'b1});
    send_byte({a, 1'b0});
    if (a != MY_ADDR) begin
      check("busy_on_mismatch", 32'(busy), 32'd0);
      bus_stop();
      return;
    end
    check("busy_after_match", 32'(busy), 32'd1);
    exp_bus.push_back({1'b0, 7'd0, (r < 16) ? 1'b0 : 1'b1});
    send_byte(8'(r));
    if (r >= 16) begin
      check("busy_after_reg_nack", 32'(busy), 32'd0);
      bus_stop();
      return;
    end
    mptr = r;
    for (int k = 0; k < n; k++) begin
      d = data[8*k +: 8];
      mregs[mptr] = d;
      exp_wr.push_back({8'(mptr), d});
      exp_bus.push_back(9'd0);
      model_adv();
      send_byte(d);
    end
    if (do_stop) begin
      bus_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
    end else begin
      open = 1'b1;
    end
  endtask

  task automatic read_txn(input int n);
    bus_start();
    exp_bus.push_back(9'd0);
    send_byte({MY_ADDR, 1'b1});
    for (int k = 0; k < n; k++) begin
      exp_bus.push_back({1'b1, mregs[mptr]});
      model_adv();
      recv_byte((k == n - 1) ? 1'b1 : 1'b0);
    end
    hold(4);
    check("sda_released_after_nack", 32'(sda_oe), 32'd0);
    bus_stop();
    check("busy_after_read_stop", 32'(busy), 32'd0);
  endtask

  task automatic do_reset_release();
    scl = 1'b1;
    m_sda = 1'b1;
    hold(4);
    reset = 1'b0;
    hold(Q);
  endtask

  // Scoreboard monitor: compares write strobes and master-observed bus responses
  always @(negedge clk) begin
    logic [8:0]  ba;
    logic [8:0]  be;
    logic [15:0] we;
    if (wr_strobe) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr_strobe: got addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
      end else begin
        we = exp_wr.pop_front();
        check("wr_strobe_addr_data", 32'({wr_addr, wr_data}), 32'(we));
      end
    end
    while (act_bus.size() > 0) begin
      ba = act_bus.pop_front();
      if (exp_bus.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bus_response: got 0x%0h, expected none", ba);
      end else begin
        be = exp_bus.pop_front();
        check(be[8] ? "read_byte" : "ack_bit", 32'(ba), 32'(be));
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit open;
    logic s;
    int r;
    int n;
    logic [6:0] a;
    logic [23:0] d;

    model_reset();
    hold(3);
    check("reset_sda_oe", 32'(sda_oe), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_wr_strobe", 32'(wr_strobe), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    do_reset_release();

    // Directed scenarios
    write_txn(MY_ADDR, 3, 1, 24'h0000AA, 1'b1, open);
    write_txn(MY_ADDR, 3, 0, 24'h0, 1'b0, open);
    if (open) read_txn(1);
    write_txn(7'h68, 3, 1, 24'h000055, 1'b1, open);
    write_txn(MY_ADDR, 8'hFB, 0, 24'h0, 1'b1, open);
    write_txn(MY_ADDR, 15, 2, 24'h002211, 1'b1, open);
    write_txn(MY_ADDR, 15, 0, 24'h0, 1'b0, open);
    if (open) read_txn(2);

    // Randomized transactions
    for (int it = 0; it < 14; it++) begin
      r = $urandom_range(0, 19);
      n = $urandom_range(1, 3);
      d = 24'($urandom());
      a = ($urandom_range(0, 5) == 0) ? 7'h68 : MY_ADDR;
      if ($urandom_range(0, 1) == 1) begin
        write_txn(a, r, n, d, 1'b1, open);
      end else begin
        write_txn(a, r, 0, 24'h0, 1'b0, open);
        if (open) read_txn($urandom_range(1, 3));
      end
    end

    // Reset while the target drives a 0 data bit: SDA must release immediately
    write_txn(MY_ADDR, 2, 1, 24'h000000, 1'b0, open);
    bus_start();
    exp_bus.push_back(9'd0);
    send_byte({MY_ADDR, 1'b1});
    bus_bit(1'b1, s);
    m_sda = 1'b1; hold(Q);
    scl = 1'b1; hold(Q);
    check("sda_oe_driving_before_reset", 32'(sda_oe), 32'd1);
    reset = 1'b1;
    #1;
    check("sda_oe_async_release", 32'(sda_oe), 32'd0);
    model_reset();
    do_reset_release();

    // Reset during bit 5 of a data byte: partial byte discarded
    write_txn(MY_ADDR, 4, 0, 24'h0, 1'b0, open);
    bus_bit(1'b1, s);
    bus_bit(1'b0, s);
    m_sda = 1'b1; hold(Q);
    scl = 1'b1; hold(Q);
    reset = 1'b1;
    #1;
    check("sda_oe_reset_mid_write", 32'(sda_oe), 32'd0);
    hold(2);
    check("wr_strobe_in_reset", 32'(wr_strobe), 32'd0);
    model_reset();
    do_reset_release();

    // Registers must read back cleared
    write_txn(MY_ADDR, 3, 0, 24'h0, 1'b0, open);
    if (open) read_txn(1);
    write_txn(MY_ADDR, 15, 0, 24'h0, 1'b0, open);
    if (open) read_txn(1);

    hold(20);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
